silent_step_filter: RTL and testbench

- Slew-rate limiter ("silent mode") for per-transducer PWM duty and phase targets.
- Every UPDATE_CYCLE clocks, each channel's smoothed duty/phase output moves toward its target by at most STEP counts. Phase moves along the shortest circular path modulo that channel's CYCLE.
- Sits between the target registers and the PWM generator. OUT_VALID tells the PWM stage when a fresh, coherent set of outputs is ready.

---
 rtl/silent_pkg.sv | 22 ++
 rtl/silent_step_unit.sv | 94 +++++++++
 rtl/silent_step_filter.sv | 141 ++++++++++++++
 tb/tb_silent_step_filter.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/silent_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : silent_pkg
//  Description : Shared types and helpers for the silent-mode step filter.
//  Revision    : 1.0 - initial release
// ============================================================================
package silent_pkg;

   // Sweep controller states
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SWEEP = 2'd1,
      DONE  = 2'd2
   } state_t;

   // Channel-index width; a single channel still needs one index bit
   function automatic int idx_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/silent_step_unit.sv
`default_nettype none
// ============================================================================
//  Module      : silent_step_unit
//  Description : Combinational next-value calculator for one channel. Duty
//                moves linearly, phase moves along the shortest circular path
//                modulo CYCLE. Both snap to the raw target when within STEP.
//  Revision    : 1.0 - initial release
// ============================================================================
module silent_step_unit #(
   parameter int WIDTH = 13
) (
   input  logic             enable,
   input  logic [WIDTH-1:0] step,
   input  logic [WIDTH-1:0] cycle,
   input  logic [WIDTH-1:0] duty_tgt,
   input  logic [WIDTH-1:0] duty_cur,
   input  logic [WIDTH-1:0] phase_tgt,
   input  logic [WIDTH-1:0] phase_cur,
   output logic [WIDTH-1:0] duty_next,
   output logic [WIDTH-1:0] phase_next
);

   // Two extra bits: one for sign, one so 2*d and s+STEP never overflow
   localparam int c_sw = WIDTH + 2;

   logic [WIDTH:0]         w_cur_plus;
   logic [WIDTH:0]         w_tgt_plus;
   logic signed [c_sw-1:0] w_cyc;
   logic signed [c_sw-1:0] w_stp;
   logic signed [c_sw-1:0] w_tgt;
   logic signed [c_sw-1:0] w_cur;
   logic signed [c_sw-1:0] w_p;
   logic signed [c_sw-1:0] w_s;
   logic signed [c_sw-1:0] w_d;
   logic signed [c_sw-1:0] w_b;
   logic signed [c_sw-1:0] w_fwd;
   logic signed [c_sw-1:0] w_bwd;
   logic                   w_unused;

   assign w_cur_plus = {1'b0, duty_cur} + {1'b0, step};
   assign w_tgt_plus = {1'b0, duty_tgt} + {1'b0, step};

   assign w_cyc = $signed({2'b00, cycle});
   assign w_stp = $signed({2'b00, step});
   assign w_tgt = $signed({2'b00, phase_tgt});
   assign w_cur = $signed({2'b00, phase_cur});

   // Duty: step toward target, snap exactly once within one step
   always_comb begin
      duty_next = duty_tgt;
      if (enable) begin
         if ({1'b0, duty_tgt} > w_cur_plus) begin
            duty_next = w_cur_plus[WIDTH-1:0];
         end else if (w_tgt_plus < {1'b0, duty_cur}) begin
            duty_next = duty_cur - step;
         end
      end
   end

   // Phase: normalise, pick shorter direction (ties forward), step or snap
   always_comb begin
      w_p = (w_tgt >= w_cyc) ? (w_tgt - w_cyc) : w_tgt;
      w_s = (w_cur >= w_cyc) ? (w_cur - w_cyc) : w_cur;
      w_d = w_p - w_s;
      if (w_d[c_sw-1]) begin
         w_d = w_d + w_cyc;
      end
      w_b = w_cyc - w_d;
      w_fwd = w_s + w_stp;
      if (w_fwd >= w_cyc) begin
         w_fwd = w_fwd - w_cyc;
      end
      w_bwd = w_s - w_stp;
      if (w_bwd[c_sw-1]) begin
         w_bwd = w_bwd + w_cyc;
      end
      // Raw target is the default so a PHASE equal to CYCLE is kept as-is
      phase_next = phase_tgt;
      if (enable && (w_d != '0)) begin
         if ((w_d <<< 1) <= w_cyc) begin
            if (w_d > w_stp) begin
               phase_next = w_fwd[WIDTH-1:0];
            end
         end else if (w_b > w_stp) begin
            phase_next = w_bwd[WIDTH-1:0];
         end
      end
   end

   // Upper bits of the wrapped results are always zero once in range
   assign w_unused = ^{w_fwd[c_sw-1:WIDTH], w_bwd[c_sw-1:WIDTH]};

endmodule
`default_nettype wire

// File: rtl/silent_step_filter.sv
`default_nettype none
// ============================================================================
//  Module      : silent_step_filter
//  Description : Slew-rate limiter for per-channel PWM duty/phase targets.
//                A period counter starts a sweep that updates one channel per
//                clock through a shared step unit, then pulses OUT_VALID.
//  Revision    : 1.0 - initial release
// ============================================================================
module silent_step_filter
   import silent_pkg::*;
#(
   parameter int WIDTH = 13,
   parameter int DEPTH = 1
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             ENABLE,
   input  logic [WIDTH-1:0] STEP,
   input  logic [WIDTH-1:0] UPDATE_CYCLE,
   input  logic [WIDTH-1:0] CYCLE   [0:DEPTH-1],
   input  logic [WIDTH-1:0] DUTY    [0:DEPTH-1],
   input  logic [WIDTH-1:0] PHASE   [0:DEPTH-1],
   output logic [WIDTH-1:0] DUTY_S  [0:DEPTH-1],
   output logic [WIDTH-1:0] PHASE_S [0:DEPTH-1],
   output logic             OUT_VALID
);

   localparam int                 c_idx_w    = idx_width(DEPTH);
   localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(DEPTH - 1);

   logic [WIDTH-1:0]   r_count;
   logic               w_tick;
   state_t             r_state;
   logic [c_idx_w-1:0] r_idx;
   logic               r_out_valid;

   logic [WIDTH-1:0]   w_cycle;
   logic [WIDTH-1:0]   w_duty_tgt;
   logic [WIDTH-1:0]   w_duty_cur;
   logic [WIDTH-1:0]   w_phase_tgt;
   logic [WIDTH-1:0]   w_phase_cur;
   logic [WIDTH-1:0]   w_duty_next;
   logic [WIDTH-1:0]   w_phase_next;

   // Tick on the last count; >= keeps it safe if UPDATE_CYCLE shrinks mid-count
   assign w_tick = (UPDATE_CYCLE <= WIDTH'(1)) ||
                   (r_count >= (UPDATE_CYCLE - WIDTH'(1)));

   // Period counter 0..UPDATE_CYCLE-1
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_count <= '0;
      end else if (w_tick) begin
         r_count <= '0;
      end else begin
         r_count <= r_count + WIDTH'(1);
      end
   end

   // Sweep controller: one channel per clock, then a single-cycle valid
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state     <= IDLE;
         r_idx       <= '0;
         r_out_valid <= 1'b0;
      end else begin
         r_out_valid <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_tick) begin
                  r_state <= SWEEP;
                  r_idx   <= '0;
               end
            end
            SWEEP: begin
               if (r_idx == c_last_idx) begin
                  r_state     <= DONE;
                  r_out_valid <= 1'b1;
               end else begin
                  r_idx <= r_idx + c_idx_w'(1);
               end
            end
            DONE: begin
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign OUT_VALID = r_out_valid;

   // Select the channel currently being swept for the shared step unit
   always_comb begin
      w_cycle     = '0;
      w_duty_tgt  = '0;
      w_duty_cur  = '0;
      w_phase_tgt = '0;
      w_phase_cur = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (r_idx == c_idx_w'(i)) begin
            w_cycle     = CYCLE[i];
            w_duty_tgt  = DUTY[i];
            w_duty_cur  = DUTY_S[i];
            w_phase_tgt = PHASE[i];
            w_phase_cur = PHASE_S[i];
         end
      end
   end

   silent_step_unit #(
      .WIDTH (WIDTH)
   ) u_step (
      .enable     (ENABLE),
      .step       (STEP),
      .cycle      (w_cycle),
      .duty_tgt   (w_duty_tgt),
      .duty_cur   (w_duty_cur),
      .phase_tgt  (w_phase_tgt),
      .phase_cur  (w_phase_cur),
      .duty_next  (w_duty_next),
      .phase_next (w_phase_next)
   );

   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_chan
      // Output registers: written only in this channel's sweep slot
      always_ff @(posedge CLK or posedge RST) begin
         if (RST) begin
            DUTY_S[gi]  <= '0;
            PHASE_S[gi] <= '0;
         end else if ((r_state == SWEEP) && (r_idx == c_idx_w'(gi))) begin
            DUTY_S[gi]  <= w_duty_next;
            PHASE_S[gi] <= w_phase_next;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_silent_step_filter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_silent_step_filter
//  Description : Directed self-checking bench for silent_step_filter with
//                hand-computed duty/phase sequences (CYCLE=5000, STEP=100).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_silent_step_filter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        enable = 1'b1;
   logic [12:0] step = 13'd100;
   logic [12:0] update_cycle = 13'd1250;
   logic [12:0] cycle   [0:0];
   logic [12:0] duty    [0:0];
   logic [12:0] phase   [0:0];
   logic [12:0] duty_s  [0:0];
   logic [12:0] phase_s [0:0];
   logic        out_valid;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   silent_step_filter #(
      .WIDTH (13),
      .DEPTH (1)
   ) dut (
      .CLK          (clk),
      .RST          (rst),
      .ENABLE       (enable),
      .STEP         (step),
      .UPDATE_CYCLE (update_cycle),
      .CYCLE        (cycle),
      .DUTY         (duty),
      .PHASE        (phase),
      .DUTY_S       (duty_s),
      .PHASE_S      (phase_s),
      .OUT_VALID    (out_valid)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Count negedges until OUT_VALID is seen, bounded by budget
   task automatic wait_pulse(input int budget, output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while ((out_valid !== 1'b1) && (n < budget));
      chk("pulse_seen", {31'd0, out_valid}, 32'd1);
   endtask

   task automatic step_chk(input string tag, input int exp_duty, input int exp_phase);
      int n;
      wait_pulse(3000, n);
      chk({tag, "_duty"}, {19'd0, duty_s[0]}, exp_duty);
      chk({tag, "_phase"}, {19'd0, phase_s[0]}, exp_phase);
   endtask

   function automatic int circ_dist(input int a, input int b);
      int x;
      x = (a % 5000) - (b % 5000);
      if (x < 0) x = -x;
      if (5000 - x < x) x = 5000 - x;
      return x;
   endfunction

   initial begin
      int n;
      int pd;
      int pp;
      int dd;
      int td;
      int tp;
      cycle[0] = 13'd5000;
      duty[0]  = 13'd0;
      phase[0] = 13'd0;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_duty", {19'd0, duty_s[0]}, 0);
      chk("rst_phase", {19'd0, phase_s[0]}, 0);
      chk("rst_valid", {31'd0, out_valid}, 0);
      rst = 1'b0;

      // First pulse latency and period
      wait_pulse(3000, n);
      chk("first_latency", n, 1251);
      @(negedge clk);
      chk("valid_one_clk", {31'd0, out_valid}, 0);
      wait_pulse(3000, n);
      chk("period_1250", n + 1, 1250);

      // Short period for directed stepping
      update_cycle = 13'd8;
      duty[0]  = 13'd250;
      phase[0] = 13'd4900;
      step_chk("ramp1", 100, 4900);
      step_chk("ramp2", 200, 4900);
      step_chk("snap", 250, 4900);
      phase[0] = 13'd4950;
      step_chk("near", 250, 4950);
      phase[0] = 13'd50;
      duty[0]  = 13'd0;
      step_chk("wrap_fwd", 150, 50);
      phase[0] = 13'd4900;
      step_chk("wrap_back1", 50, 4950);
      step_chk("wrap_back2", 0, 4900);
      phase[0] = 13'd0;
      step_chk("to_zero", 0, 0);
      phase[0] = 13'd5000;
      step_chk("eq_cycle", 0, 5000);
      phase[0] = 13'd2500;
      step_chk("tie_fwd", 0, 100);

      // STEP=0 holds outputs
      step     = 13'd0;
      phase[0] = 13'd3000;
      duty[0]  = 13'd4000;
      step_chk("step0", 0, 100);

      // Bypass mode loads targets directly
      step     = 13'd100;
      enable   = 1'b0;
      duty[0]  = 13'd4321;
      phase[0] = 13'd1234;
      step_chk("bypass", 4321, 1234);
      update_cycle = 13'd1250;
      wait_pulse(3000, n);
      wait_pulse(3000, n);
      chk("bypass_period", n, 1250);
      chk("bypass_hold_duty", {19'd0, duty_s[0]}, 4321);
      chk("bypass_hold_phase", {19'd0, phase_s[0]}, 1234);

      // Random-to-random convergence with slew bounds
      enable = 1'b1;
      update_cycle = 13'd8;
      for (int r = 0; r < 2; r++) begin
         td = $urandom_range(0, 5000);
         tp = $urandom_range(0, 5000);
         duty[0]  = 13'(td);
         phase[0] = 13'(tp);
         for (int k = 0; k < 55; k++) begin
            pd = int'(duty_s[0]);
            pp = int'(phase_s[0]);
            wait_pulse(3000, n);
            dd = int'(duty_s[0]) - pd;
            if (dd < 0) dd = -dd;
            chk("slew_duty", {31'd0, dd <= 100}, 1);
            chk("slew_phase", {31'd0, circ_dist(int'(phase_s[0]), pp) <= 100}, 1);
         end
         chk("conv_duty", {19'd0, duty_s[0]}, td);
         chk("conv_phase", {19'd0, phase_s[0]}, tp);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
